// File: rtl/dense_output_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dense_output_stage_pkg
//  Purpose  : Shared defaults, FSM state encoding and saturation limits for
//             the dense classifier output stage.
//  Contents : default sizes, state_t, score saturation constants, and a
//             helper that returns the clamp limits for any score width.
//  Revision : 1.0  initial release
// ============================================================================
package dense_output_stage_pkg;

    localparam int WORD_SIZE_DEF = 32;
    localparam int NEURONS_DEF   = 10;
    localparam int ADR_SIZE_DEF  = 4;
    localparam int INPUTS_DEF    = 128;
    localparam int CNT_SIZE_DEF  = 8;
    localparam int ACC_SIZE_DEF  = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_BIAS  = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Clamp limits of a default-width score.
    localparam logic [WORD_SIZE_DEF-1:0] c_score_max = {1'b0, {(WORD_SIZE_DEF-1){1'b1}}};
    localparam logic [WORD_SIZE_DEF-1:0] c_score_min = {1'b1, {(WORD_SIZE_DEF-1){1'b0}}};

    // Upper clamp limit of a w-bit signed score, as a 64-bit signed value.
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Lower clamp limit of a w-bit signed score, as a 64-bit signed value.
    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_output_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : dense_output_stage_if
//  Purpose  : Bundles the product stream, bias LUT port and result signals of
//             the dense output stage.
//  Ports    : start, prodIn/prodValid/prodReady (product stream),
//             biasAdr/biasData (combinational bias LUT),
//             scoreOut/scoreIdx/scoreValid (per-neuron score strobe),
//             classOut/done/busy (inference result and status).
//  Modports : slave  - the output stage itself
//             master - the surrounding logic (MAC array, LUT, readout)
//  Revision : 1.0  initial release
// ============================================================================
interface dense_output_stage_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADR_SIZE  = 4
);
    logic                 start;
    logic [WORD_SIZE-1:0] prodIn;
    logic                 prodValid;
    logic                 prodReady;
    logic [ADR_SIZE-1:0]  biasAdr;
    logic [WORD_SIZE-1:0] biasData;
    logic [WORD_SIZE-1:0] scoreOut;
    logic [ADR_SIZE-1:0]  scoreIdx;
    logic                 scoreValid;
    logic [ADR_SIZE-1:0]  classOut;
    logic                 done;
    logic                 busy;

    modport slave (
        input  start, prodIn, prodValid, biasData,
        output prodReady, biasAdr, scoreOut, scoreIdx, scoreValid,
               classOut, done, busy
    );

    modport master (
        output start, prodIn, prodValid, biasData,
        input  prodReady, biasAdr, scoreOut, scoreIdx, scoreValid,
               classOut, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/dense_output_stage_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : sat_add
//  Purpose  : Combinational signed add of an ACC_SIZE accumulator and a
//             WORD_SIZE addend, clamped to the WORD_SIZE signed range.
//  Ports    : acc    in  ACC_SIZE   signed accumulator
//             addend in  WORD_SIZE  signed addend (e.g. bias)
//             sum    out WORD_SIZE  saturated result
//  Revision : 1.0  initial release
// ============================================================================
module sat_add #(
    parameter int ACC_SIZE  = 40,
    parameter int WORD_SIZE = 32
) (
    input  wire logic [ACC_SIZE-1:0]  acc,
    input  wire logic [WORD_SIZE-1:0] addend,
    output logic      [WORD_SIZE-1:0] sum
);
    // One extra bit so the full add can never overflow before clamping.
    localparam int SUM_W = ACC_SIZE + 1;

    localparam logic signed [SUM_W-1:0] c_hi = {{(SUM_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] c_lo = {{(SUM_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    logic signed [SUM_W-1:0] w_sum;

    assign w_sum = $signed({acc[ACC_SIZE-1], acc})
                 + $signed({{(SUM_W-WORD_SIZE){addend[WORD_SIZE-1]}}, addend});

    always_comb begin
        sum = w_sum[WORD_SIZE-1:0];
        if (w_sum > c_hi) begin
            sum = c_hi[WORD_SIZE-1:0];
        end else if (w_sum < c_lo) begin
            sum = c_lo[WORD_SIZE-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/dense_output_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dense_output_stage
//  Purpose  : Output-layer sequencer of the dense classifier. Accumulates
//             INPUTS signed products per neuron, adds the neuron's bias from
//             the external LUT, saturates to a WORD_SIZE score, and tracks the
//             running argmax over NEURONS neurons.
//  Ports    : clk   in  rising-edge clock
//             rstn  in  asynchronous active-low reset
//             bus   slave modport of dense_output_stage_if (product stream,
//                   bias LUT port, score strobe, class/done/busy)
//  Revision : 1.0  initial release
// ============================================================================
module dense_output_stage
    import dense_output_stage_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NEURONS   = NEURONS_DEF,
    parameter int ADR_SIZE  = ADR_SIZE_DEF,
    parameter int INPUTS    = INPUTS_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF,
    parameter int ACC_SIZE  = ACC_SIZE_DEF
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    dense_output_stage_if.slave bus
);
    state_t r_state;
    state_t w_state_next;

    logic [ADR_SIZE-1:0]  r_neuron;
    logic [CNT_SIZE-1:0]  r_cnt;
    logic [ACC_SIZE-1:0]  r_acc;
    logic [WORD_SIZE-1:0] r_score;
    logic [ADR_SIZE-1:0]  r_score_idx;
    logic [WORD_SIZE-1:0] r_best;
    logic [ADR_SIZE-1:0]  r_best_idx;
    logic [ADR_SIZE-1:0]  r_class;

    logic                 w_ready;
    logic                 w_score_valid;
    logic                 w_done;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_last_prod;
    logic                 w_last_neuron;
    logic                 w_better;
    logic [WORD_SIZE-1:0] w_sat;
    logic [ACC_SIZE-1:0]  w_prod_sext;

    assign w_last_prod   = (r_cnt == CNT_SIZE'(INPUTS - 1));
    assign w_last_neuron = (r_neuron == ADR_SIZE'(NEURONS - 1));
    assign w_accept      = w_ready && bus.prodValid;
    assign w_prod_sext   = {{(ACC_SIZE-WORD_SIZE){bus.prodIn[WORD_SIZE-1]}}, bus.prodIn};
    // Neuron 0 always seeds the argmax; strict compare keeps the lower index on ties.
    assign w_better      = (r_neuron == '0) || ($signed(r_score) > $signed(r_best));

    sat_add #(
        .ACC_SIZE  (ACC_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_sat_add (
        .acc    (r_acc),
        .addend (bus.biasData),
        .sum    (w_sat)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_ready       = 1'b0;
        w_score_valid = 1'b0;
        w_done        = 1'b0;
        w_busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_ready = 1'b1;
                if (bus.prodValid && w_last_prod) begin
                    w_state_next = ST_BIAS;
                end
            end
            ST_BIAS: begin
                w_state_next = ST_CMP;
            end
            ST_CMP: begin
                w_score_valid = 1'b1;
                w_state_next  = w_last_neuron ? ST_DONE : ST_ACCUM;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, score, argmax, class
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_neuron    <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_score     <= '0;
            r_score_idx <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_class     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_neuron   <= '0;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_best_idx <= '0;
                        r_class    <= '0;
                    end
                end
                ST_ACCUM: begin
                    // Accumulator wraps silently; ACC_SIZE has 8 guard bits,
                    // enough for up to 256 full-scale products.
                    if (w_accept) begin
                        r_acc <= r_acc + w_prod_sext;
                        r_cnt <= r_cnt + CNT_SIZE'(1);
                    end
                end
                ST_BIAS: begin
                    // Score and its index change together so both hold
                    // steady from this CMP until the next one.
                    r_score     <= w_sat;
                    r_score_idx <= r_neuron;
                end
                ST_CMP: begin
                    if (w_better) begin
                        r_best     <= r_score;
                        r_best_idx <= r_neuron;
                    end
                    if (w_last_neuron) begin
                        // Include this cycle's compare result in the class.
                        r_class <= w_better ? r_neuron : r_best_idx;
                    end else begin
                        r_neuron <= r_neuron + ADR_SIZE'(1);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.prodReady  = w_ready;
    assign bus.scoreValid = w_score_valid;
    assign bus.done       = w_done;
    assign bus.busy       = w_busy;
    assign bus.biasAdr    = r_neuron;
    assign bus.scoreOut   = r_score;
    assign bus.scoreIdx   = r_score_idx;
    assign bus.classOut   = r_class;

endmodule
`default_nettype wire

// File: tb/tb_dense_output_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dense_output_stage
//  Purpose  : Self-checking bench for dense_output_stage (INPUTS=4). A
//             behavioural model computes per-neuron sums, clamped scores and
//             the argmax from the product and bias tables.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dense_output_stage;
    import dense_output_stage_pkg::*;

    localparam int W  = 32;
    localparam int N  = 10;
    localparam int A  = 4;
    localparam int IN = 4;
    localparam int CS = 8;
    localparam int AS = 40;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dense_output_stage_if #(.WORD_SIZE(W), .ADR_SIZE(A)) bus ();

    logic [W-1:0] bias_lut [N];
    assign bus.biasData = (int'(bus.biasAdr) < N) ? bias_lut[bus.biasAdr] : '0;

    dense_output_stage #(
        .WORD_SIZE (W), .NEURONS (N), .ADR_SIZE (A),
        .INPUTS (IN), .CNT_SIZE (CS), .ACC_SIZE (AS)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] prods [N*IN];
    logic [W-1:0] exp_score [N];
    int           exp_class;

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return c_score_max;
            2:       return c_score_min;
            default: return W'($urandom_range(0, 200)) - W'(100);
        endcase
    endfunction

    task automatic build_model();
        longint s, best;
        best = 0;
        exp_class = 0;
        for (int k = 0; k < N; k++) begin
            s = longint'($signed(bias_lut[k]));
            for (int i = 0; i < IN; i++) s += longint'($signed(prods[k*IN+i]));
            if (s > sat_hi(W)) s = sat_hi(W);
            if (s < sat_lo(W)) s = sat_lo(W);
            exp_score[k] = W'(s);
            if (k == 0 || s > best) begin
                best = s;
                exp_class = k;
            end
        end
    endtask

    task automatic set_bias(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       bias_lut[k] = W'(k);
                1:       bias_lut[k] = W'(5);
                2:       bias_lut[k] = c_score_max;
                3:       bias_lut[k] = c_score_min;
                default: bias_lut[k] = rand_word();
            endcase
        end
    endtask

    task automatic set_prods(input logic [W-1:0] val, input bit rnd);
        for (int i = 0; i < N*IN; i++) prods[i] = rnd ? rand_word() : val;
    endtask

    // ---------------- one inference ----------------
    int           k_seen, stalls, done_cyc;
    bit           got_done;
    logic [W-1:0] first_score;
    logic [A-1:0] got_class;

    task automatic run_inf(input int vkind, input int extra_start_cyc);
        int idx = 0;
        int cyc;
        bit v;
        k_seen = 0; stalls = 0; done_cyc = -1; got_done = 0;
        first_score = '0; got_class = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.prodValid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 2000) begin
            if (bus.scoreValid) begin
                if (k_seen == 0) first_score = bus.scoreOut;
                if (k_seen < N) begin
                    check("score", bus.scoreOut, exp_score[k_seen]);
                    check("score_idx", bus.scoreIdx, k_seen);
                end else begin
                    check("score_count_over", k_seen + 1, N);
                end
                check("ready_in_cmp", bus.prodReady, 0);
                k_seen++;
            end
            if (bus.done) begin
                got_done  = 1;
                done_cyc  = cyc;
                got_class = bus.classOut;
                check("score_count", k_seen, N);
                check("class", bus.classOut, exp_class);
                check("done_cycle", cyc, 1 + N*(IN+2) + stalls);
            end else begin
                case (vkind)
                    0:       v = 1'b1;
                    1:       v = ~cyc[0];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (bus.prodReady && !v) stalls++;
                bus.prodValid = v;
                // Garbage while not ready must be ignored by the DUT.
                bus.prodIn = (bus.prodReady && idx < N*IN) ? prods[idx] : $urandom();
                if (v && bus.prodReady) idx++;
                bus.start = (cyc == extra_start_cyc);
                @(negedge clk);
                cyc++;
            end
        end
        bus.prodValid = 1'b0;
        bus.start     = 1'b0;
        check("done_seen", got_done, 1);
        if (got_done) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
            check("class_held", bus.classOut, exp_class);
            check("score_held", bus.scoreOut, exp_score[N-1]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  bus.prodReady, 0);
        check({tag, "_busy"},   bus.busy, 0);
        check({tag, "_done"},   bus.done, 0);
        check({tag, "_svalid"}, bus.scoreValid, 0);
        check({tag, "_class"},  bus.classOut, 0);
        check({tag, "_score"},  bus.scoreOut, 0);
        check({tag, "_sidx"},   bus.scoreIdx, 0);
        check({tag, "_badr"},   bus.biasAdr, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] prod;
        int           bias_kind;
        int           vkind;
        int           start_at;
        logic [W-1:0] exp_score0;
        logic [A-1:0] exp_class;
        int           exp_done;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit reached;
        tbl[0] = '{32'h1,        0, 0, -1, 32'd4,        4'd9, 61};
        tbl[1] = '{32'h0,        1, 0, -1, 32'd5,        4'd0, 61};
        tbl[2] = '{32'h7FFFFFFF, 2, 0, -1, 32'h7FFFFFFF, 4'd0, 61};
        tbl[3] = '{32'h80000000, 3, 0, -1, 32'h80000000, 4'd0, 61};
        tbl[4] = '{32'h1,        0, 1, -1, 32'd4,        4'd9, -1};
        tbl[5] = '{32'h1,        0, 0, 20, 32'd4,        4'd9, 61};

        bus.start = 1'b0; bus.prodValid = 1'b0; bus.prodIn = '0;
        set_bias(0);

        // Reset and idle with no start.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle");

        // Table-driven directed inferences.
        for (int t = 0; t < 6; t++) begin
            set_bias(tbl[t].bias_kind);
            set_prods(tbl[t].prod, 0);
            build_model();
            run_inf(tbl[t].vkind, tbl[t].start_at);
            check("tbl_score0", first_score, tbl[t].exp_score0);
            check("tbl_class", got_class, tbl[t].exp_class);
            if (tbl[t].exp_done >= 0) check("tbl_done", done_cyc, tbl[t].exp_done);
            else check("tbl_stalled", (stalls > 0 && done_cyc == 61 + stalls), 1);
        end

        // Reset in the middle of neuron 3's accumulation, with a start
        // pulse while busy.
        set_bias(0);
        set_prods(32'h1, 0);
        build_model();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.prodValid = 1'b1; bus.prodIn = 32'h1;
        reached = 0;
        for (int i = 0; i < 300 && !reached; i++) begin
            bus.start = (i == 5);
            if (bus.biasAdr == 4'd3 && bus.prodReady) reached = 1;
            else @(negedge clk);
        end
        bus.start = 1'b0;
        check("reach_neuron3", reached, 1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async");
        bus.prodValid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("post");
        run_inf(0, -1);
        check("fresh_class", got_class, 9);

        // Randomized inferences against the model.
        for (int r = 0; r < 8; r++) begin
            set_bias(4);
            set_prods('0, 1);
            build_model();
            run_inf(2, ($urandom_range(0, 1) != 0) ? int'($urandom_range(3, 60)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dense_output_stage.md
# dense_output_stage

Output-layer sequencer of the dense classifier. It accumulates a stream of signed weight×activation products for each of NEURONS output neurons and adds that neuron's bias, read from the dense bias lookup table. It saturates each result to a WORD_SIZE score and tracks the running argmax. It sits between the dense MAC array (upstream, product stream) and the result/readout logic (downstream, class index).

## Interface
- WORD_SIZE, 32: width of products, biases, scores (signed two's complement)
- NEURONS, 10: number of output neurons
- ADR_SIZE, 4: bias LUT address / class index width
- INPUTS, 128: products accumulated per neuron (1..256)
- CNT_SIZE, 8: product counter width, ≥ clog2(INPUTS)
- ACC_SIZE, 40: accumulator width, WORD_SIZE+8
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  begin one inference; sampled only in IDLE
- prodIn  in  WORD_SIZE  signed product
- prodValid  in  1  prodIn valid
- prodReady  out  1  stage accepts a product this cycle
- biasAdr  out  ADR_SIZE  bias LUT address, always equal to current neuron index
- biasData  in  WORD_SIZE  bias word, combinational response to biasAdr
- scoreOut  out  WORD_SIZE  saturated score of the neuron just finished
- scoreIdx  out  ADR_SIZE  neuron index belonging to scoreOut
- scoreValid  out  1  one-cycle strobe qualifying scoreOut/scoreIdx
- classOut  out  ADR_SIZE  argmax index, held from done until next start
- done  out  1  one-cycle strobe: inference complete
- busy  out  1  high in every state except IDLE

## Operation
- Reset: state IDLE; neuron, cnt, acc, scoreReg, best, bestIdx = 0. All outputs 0: prodReady, scoreValid, done, busy, classOut, scoreOut, scoreIdx, biasAdr.
- IDLE: on start → ACCUM; clear neuron, cnt, acc, bestIdx. start is ignored in every other state.
- ACCUM: prodReady=1. On prodValid&prodReady: acc += sign-extended prodIn; cnt++. The accept with cnt==INPUTS-1 → BIAS. acc wraps at ACC_SIZE and is not checked; this is safe by construction for INPUTS ≤ 256.
- BIAS: prodReady=0. sum = acc + sext(biasData), computed at ACC_SIZE+1 bits, clamped to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1] → scoreReg; → CMP.
- CMP: scoreValid=1, scoreOut=scoreReg, scoreIdx=neuron.
  - If neuron==0 or scoreReg > best (signed, strict): best=scoreReg, bestIdx=neuron. Ties keep the lower index.
  - If neuron==NEURONS-1 → DONE. Otherwise neuron++, acc=0, cnt=0 → ACCUM.
- DONE: done=1, classOut=bestIdx (registered, held); → IDLE.
- scoreOut/scoreIdx hold their last values outside CMP; only scoreValid qualifies them.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and classOut returns to 0.

## Timing
- start sampled in cycle 0; ACCUM from cycle 1.
- Per neuron: INPUTS accept cycles + 1 (BIAS) + 1 (CMP). With prodValid held high, done is asserted in cycle 1 + NEURONS·(INPUTS+2).
- prodValid stalls extend only ACCUM. No product is lost or double-counted. prodIn is ignored while prodReady=0.
- biasData must settle within the BIAS cycle. The LUT is combinational, so there is no added latency.
- scoreValid fires exactly NEURONS times per inference. The last strobe is in the cycle directly before done.

## Structure
- Shared package: WORD_SIZE/NEURONS/ADR_SIZE defaults, state encoding (IDLE, ACCUM, BIAS, CMP, DONE), saturation limit constants.
- One sub-module: sat_add. It is a combinational ACC_SIZE + WORD_SIZE signed add clamped to WORD_SIZE, and is reused by the other dense stages.
- The bias LUT is instantiated by the parent, not inside this block.

## Test plan
- Reset/idle: rstn low then high with no start → all outputs 0, prodReady 0, busy 0.
- INPUTS=4, all products 1, bench LUT bias[k]=k, prodValid always high → scores 4..13 with scoreIdx 0..9; classOut=9; done in cycle 61.
- Tie: all products 0, all biases 5 → every score 5; classOut=0.
- Saturation: INPUTS=4, products 0x7FFFFFFF, bias 0x7FFFFFFF → score 0x7FFFFFFF. Products 0x80000000, bias 0x80000000 → score 0x80000000.
- Backpressure: same stimulus as the second scenario with prodValid toggling 1-0 → identical scores and classOut. prodReady is low in BIAS/CMP. done arrives later by exactly the number of idle prodValid cycles.
- Reset mid-ACCUM of neuron 3, plus start pulsed while busy → IDLE and outputs 0 after reset. A fresh start yields correct results. The ignored start has no effect on the running inference.
